ifft_cross_seq: RTL

Sequential radix-2 inverse-FFT butterfly stage. It pairs with the forward combinational butterfly in the same signal-processing chain.
- Accepts one complex frame of SIZE samples serially over a valid/ready stream and stores it locally.
- Computes SIZE/2 inverse butterflies, one per cycle, using conjugate twiddles.
- Streams the SIZE results out in natural order with backpressure.
- Sits at the end of the IFFT chain: the frequency-domain processor feeds it, and the output goes to the time-domain consumer.

---
 rtl/ifft_cross_seq_if.sv | 36 +++
 rtl/ifft_cross_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ifft_cross_seq_if.sv
// Stream bundle for the inverse butterfly stage: a valid/ready input port
// carrying one complex sample, and a valid/ready output port carrying one
// result plus its position in the frame.
interface ifft_cross_seq_if #(
  parameter int SIZE       = 8,
  parameter int BITS       = 16,
  parameter int RESOLUTION = 4,
  parameter int TRUNCATION = 4
);
  localparam int OW = BITS + RESOLUTION - TRUNCATION + 1;
  localparam int AW = $clog2(SIZE);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [BITS-1:0] in_re;
  logic signed [BITS-1:0] in_im;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_re;
  logic signed [OW-1:0] out_im;
  logic [AW-1:0]        out_index;
  logic                 out_last;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_index, out_last
  );

  // Butterfly block side.
  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_index, out_last
  );
endinterface

// File: rtl/ifft_cross_seq.sv
// Sequential radix-2 inverse butterfly stage. Loads one frame of SIZE complex
// samples, runs SIZE/2 butterflies (one per cycle) with conjugate twiddles,
// then streams the SIZE results out in natural order under backpressure.
module ifft_cross_seq #(
  parameter int SIZE       = 8,
  parameter int BITS       = 16,
  parameter int RESOLUTION = 4,
  parameter int TRUNCATION = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  ifft_cross_seq_if.slave  bus
);
  localparam int OW   = BITS + RESOLUTION - TRUNCATION + 1;
  localparam int AW   = $clog2(SIZE);
  localparam int HALF = SIZE / 2;
  localparam int IW   = BITS + RESOLUTION + 3;  // butterfly intermediate width
  localparam int TW   = RESOLUTION + 2;         // twiddle width

  localparam logic [AW-1:0] LAST_IDX  = AW'(SIZE - 1);
  localparam logic [AW-1:0] HALF_LAST = AW'(HALF - 1);
  localparam logic [AW-1:0] HALF_OFF  = AW'(HALF);

  localparam real PI_R = 3.14159265358979323846;

  localparam logic [1:0] S_LOAD    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_UNLOAD  = 2'd2;

  // Rounded (half away from zero) twiddle; sine is taken positive, which is
  // the conjugate of the forward stage's coefficient.
  function automatic logic signed [TW-1:0] twiddle(input int k, input bit use_sin);
    real ang;
    real v;
    ang = 2.0 * PI_R * real'(k) / real'(SIZE);
    v   = (use_sin ? $sin(ang) : $cos(ang)) * real'(1 << RESOLUTION);
    if (v >= 0.0) return TW'($rtoi(v + 0.5));
    else          return TW'(-$rtoi(0.5 - v));
  endfunction

  logic signed [TW-1:0] tw_re [SIZE];
  logic signed [TW-1:0] tw_im [SIZE];

  for (genvar g = 0; g < SIZE; g++) begin : g_tw
    localparam logic signed [TW-1:0] WR = twiddle(g, 1'b0);
    localparam logic signed [TW-1:0] WI = twiddle(g, 1'b1);
    assign tw_re[g] = WR;
    assign tw_im[g] = WI;
  end

  logic [BITS-1:0] in_re_buf  [SIZE];
  logic [BITS-1:0] in_im_buf  [SIZE];
  logic [OW-1:0]   res_re_buf [SIZE];
  logic [OW-1:0]   res_im_buf [SIZE];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] n_q, n_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] m_q, m_d;
  logic          out_valid_q, out_valid_d;
  logic [OW-1:0] out_re_q, out_re_d;
  logic [OW-1:0] out_im_q, out_im_d;

  logic          in_wr;
  logic          bf_wr;
  logic [AW-1:0] b_idx;
  logic [AW-1:0] m_nxt;

  logic signed [IW-1:0] a_re, a_im, b_re, b_im, w_re, w_im, p_re, p_im;
  logic [OW-1:0]        sum_re, sum_im, dif_re, dif_im;

  // Butterfly datapath for the pair selected by k.
  // NOTE: combinational blocks use blocking '=' so each line sees the value
  // computed just above it; clocked blocks use '<=' so all flops update together.
  always_comb begin
    b_idx  = k_q + HALF_OFF;
    a_re   = IW'(signed'(in_re_buf[k_q])) <<< RESOLUTION;
    a_im   = IW'(signed'(in_im_buf[k_q])) <<< RESOLUTION;
    b_re   = IW'(signed'(in_re_buf[b_idx]));
    b_im   = IW'(signed'(in_im_buf[b_idx]));
    w_re   = IW'(tw_re[k_q]);
    w_im   = IW'(tw_im[k_q]);
    p_re   = w_re * b_re - w_im * b_im;
    p_im   = w_re * b_im + w_im * b_re;
    sum_re = OW'((a_re + p_re) >>> TRUNCATION);
    sum_im = OW'((a_im + p_im) >>> TRUNCATION);
    dif_re = OW'((a_re - p_re) >>> TRUNCATION);
    dif_im = OW'((a_im - p_im) >>> TRUNCATION);
  end

  // Sequencing: load counter, butterfly counter, unload counter and output regs.
  always_comb begin
    // NOTE: every output gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d     = state_q;
    n_d         = n_q;
    k_d         = k_q;
    m_d         = m_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    in_wr       = 1'b0;
    bf_wr       = 1'b0;
    m_nxt       = m_q + AW'(1);
    case (state_q)
      S_LOAD: begin
        if (bus.in_valid) begin
          in_wr = 1'b1;
          n_d   = n_q + AW'(1);
          if (n_q == LAST_IDX) begin
            n_d     = '0;
            state_d = S_COMPUTE;
          end
        end
      end
      S_COMPUTE: begin
        bf_wr = 1'b1;
        k_d   = k_q + AW'(1);
        if (k_q == HALF_LAST) begin
          k_d     = '0;
          state_d = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        if (!out_valid_q) begin
          // First cycle in UNLOAD: present result[0].
          out_valid_d = 1'b1;
          out_re_d    = res_re_buf[m_q];
          out_im_d    = res_im_buf[m_q];
        end else if (bus.out_ready) begin
          if (m_q == LAST_IDX) begin
            out_valid_d = 1'b0;
            m_d         = '0;
            state_d     = S_LOAD;
          end else begin
            m_d      = m_nxt;
            out_re_d = res_re_buf[m_nxt];
            out_im_d = res_im_buf[m_nxt];
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      n_q         <= '0;
      k_q         <= '0;
      m_q         <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      m_q         <= m_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  // Sample and result buffers.
  // NOTE: the buffers have no reset; every entry is rewritten by the current
  // frame before it is read, so stale contents can never reach the output.
  always_ff @(posedge clk) begin
    if (in_wr) begin
      in_re_buf[n_q] <= bus.in_re;
      in_im_buf[n_q] <= bus.in_im;
    end
    if (bf_wr) begin
      res_re_buf[k_q]   <= sum_re;
      res_im_buf[k_q]   <= sum_im;
      res_re_buf[b_idx] <= dif_re;
      res_im_buf[b_idx] <= dif_im;
    end
  end

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.out_index = m_q;
  assign bus.out_last  = (m_q == LAST_IDX);

endmodule
